frame_streamer: RTL and testbench

Source-side companion for the conv/ReLU/pool pipeline: holds one IMG_W x IMG_H 8-bit frame in an internal buffer, presents a latched 3x3 coefficient vector, and on `start` streams the frame in raster order over a valid/ready pixel interface into the accelerator's `i_x`/`i_valid`/`i_f` inputs. It sits between the host/testbench load path and the accelerator input.

---
 rtl/frame_streamer.sv | 149 ++++++++++++++
 tb/tb_frame_streamer.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/frame_streamer.sv
// Frame source for the conv/ReLU/pool pipeline: buffers one frame and streams it in raster order.
// Optional FRAME_STREAMER_CHECKSUM_EN adds a 16-bit running sum of transferred pixels.
module frame_streamer #(
   parameter int PIXEL_DATAW = 8,
   parameter int COEFF_DATAW = 8,
   parameter int IMG_W       = 24,
   parameter int IMG_H       = 24
) (
   input  logic                              clk,
   input  logic                              reset_n,
   input  logic                              wr_en,
   input  logic [$clog2(IMG_W*IMG_H)-1:0]    wr_addr,
   input  logic [PIXEL_DATAW-1:0]            wr_data,
   input  logic [9*COEFF_DATAW-1:0]          coeff_in,
   input  logic                              start,
   output logic                              busy,
   output logic                              done,
   output logic [9*COEFF_DATAW-1:0]          o_f,
   output logic                              o_valid,
   input  logic                              i_ready,
   output logic [PIXEL_DATAW-1:0]            o_x,
   output logic                              o_sof,
   output logic                              o_eol
`ifdef FRAME_STREAMER_CHECKSUM_EN
   ,
   output logic [15:0]                       o_checksum
`endif
);

   localparam int NPIX = IMG_W * IMG_H;
   localparam int AW   = $clog2(NPIX);
   localparam int CW   = $clog2(IMG_W);
   localparam int RW   = $clog2(IMG_H);

   typedef enum logic [1:0] {IDLE, LATCH, STREAM, DONE} state_t;

   logic [PIXEL_DATAW-1:0]   mem [NPIX];

   state_t                   state_q, state_d;
   logic [CW-1:0]            col_q, col_d;
   logic [RW-1:0]            row_q, row_d;
   logic [AW-1:0]            addr_q, addr_d, addr_nxt;
   logic [PIXEL_DATAW-1:0]   o_x_q, o_x_d;
   logic [9*COEFF_DATAW-1:0] o_f_q, o_f_d;
   logic                     o_valid_q, busy_q, done_q;
   logic                     xfer, last_col, last_px;
`ifdef FRAME_STREAMER_CHECKSUM_EN
   logic [15:0]              cks_q, cks_d;
`endif

   assign addr_nxt = addr_q + AW'(1);
   assign last_col = (col_q == CW'(IMG_W - 1));
   assign last_px  = last_col && (row_q == RW'(IMG_H - 1));
   // In STREAM o_valid is always high, so a transfer is just ready in STREAM.
   assign xfer     = (state_q == STREAM) && i_ready;

   always_comb begin
      state_d = state_q;
      col_d   = col_q;
      row_d   = row_q;
      addr_d  = addr_q;
      o_x_d   = o_x_q;
      o_f_d   = o_f_q;
`ifdef FRAME_STREAMER_CHECKSUM_EN
      cks_d   = cks_q;
      if (xfer) cks_d = cks_q + 16'(o_x_q);
`endif
      case (state_q)
         IDLE:   if (start) state_d = LATCH;
         LATCH: begin
            o_f_d   = coeff_in;
            col_d   = '0;
            row_d   = '0;
            addr_d  = '0;
            o_x_d   = mem[0];
            state_d = STREAM;
`ifdef FRAME_STREAMER_CHECKSUM_EN
            cks_d   = '0;
`endif
         end
         STREAM: begin
            if (xfer) begin
               if (last_px) begin
                  state_d = DONE;
               end else begin
                  addr_d = addr_nxt;
                  o_x_d  = mem[addr_nxt];
                  if (last_col) begin
                     col_d = '0;
                     row_d = row_q + RW'(1);
                  end else begin
                     col_d = col_q + CW'(1);
                  end
               end
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= IDLE;
         col_q     <= '0;
         row_q     <= '0;
         addr_q    <= '0;
         o_x_q     <= '0;
         o_f_q     <= '0;
         o_valid_q <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
`ifdef FRAME_STREAMER_CHECKSUM_EN
         cks_q     <= '0;
`endif
      end else begin
         state_q   <= state_d;
         col_q     <= col_d;
         row_q     <= row_d;
         addr_q    <= addr_d;
         o_x_q     <= o_x_d;
         o_f_q     <= o_f_d;
         o_valid_q <= (state_d == STREAM);
         busy_q    <= (state_d != IDLE);
         done_q    <= (state_d == DONE);
`ifdef FRAME_STREAMER_CHECKSUM_EN
         cks_q     <= cks_d;
`endif
      end
   end

   // Buffer is frozen outside IDLE so a frame always streams a consistent image.
   always_ff @(posedge clk) begin
      if (wr_en && (state_q == IDLE) && ({1'b0, wr_addr} < (AW+1)'(NPIX)))
         mem[wr_addr] <= wr_data;
   end

   assign o_x     = o_x_q;
   assign o_f     = o_f_q;
   assign o_valid = o_valid_q;
   assign busy    = busy_q;
   assign done    = done_q;
   assign o_sof   = (col_q == '0) && (row_q == '0);
   assign o_eol   = last_col;
`ifdef FRAME_STREAMER_CHECKSUM_EN
   assign o_checksum = cks_q;
`endif

endmodule

// File: tb/tb_frame_streamer.sv
// Scoreboard bench for frame_streamer: ramp frame, stalls, ignored start/write, mid-frame reset.
module tb_frame_streamer;

   localparam int W = 24, H = 24, NP = W * H;

   typedef struct packed {
      logic [7:0] x;
      logic       sof;
      logic       eol;
   } beat_t;

   logic        clk = 1'b0, reset_n = 1'b0;
   logic        wr_en = 1'b0, start = 1'b0, i_ready = 1'b1;
   logic [9:0]  wr_addr = '0;
   logic [7:0]  wr_data = '0;
   logic [71:0] coeff_in = '0;
   logic        busy, done, o_valid, o_sof, o_eol;
   logic [71:0] o_f;
   logic [7:0]  o_x;
`ifdef FRAME_STREAMER_CHECKSUM_EN
   logic [15:0] o_checksum;
`endif

   frame_streamer #(.PIXEL_DATAW(8), .COEFF_DATAW(8), .IMG_W(W), .IMG_H(H)) dut (
      .clk(clk), .reset_n(reset_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .coeff_in(coeff_in), .start(start), .busy(busy), .done(done), .o_f(o_f),
      .o_valid(o_valid), .i_ready(i_ready), .o_x(o_x), .o_sof(o_sof), .o_eol(o_eol)
`ifdef FRAME_STREAMER_CHECKSUM_EN
      , .o_checksum(o_checksum)
`endif
   );

   always #5 clk = ~clk;

   int    n_chk = 0, n_fail = 0;
   beat_t sbq[$];
   bit    mon_en = 1'b0;
   int    mon_xfers = 0;
   bit    prev_stall = 1'b0;
   beat_t prev_b;

   // Scoreboard: every accepted beat is popped and compared; stalls must hold the outputs.
   always @(negedge clk) begin
      if (mon_en) begin
         if (prev_stall) begin
            n_chk++;
            if (o_valid !== 1'b1 || o_x !== prev_b.x || o_eol !== prev_b.eol || o_sof !== prev_b.sof) begin
               n_fail++;
               $display("FAIL stall_hold: got v=%b x=%h sof=%b eol=%b, need v=1 x=%h sof=%b eol=%b",
                        o_valid, o_x, o_sof, o_eol, prev_b.x, prev_b.sof, prev_b.eol);
            end
         end
         if (o_valid && i_ready) begin
            n_chk++;
            if (sbq.size() == 0) begin
               n_fail++;
               $display("FAIL beat_extra: got x=%h with empty scoreboard", o_x);
            end else begin
               beat_t e;
               e = sbq.pop_front();
               if (o_x !== e.x || o_sof !== e.sof || o_eol !== e.eol) begin
                  n_fail++;
                  $display("FAIL beat %0d: got x=%h sof=%b eol=%b, need x=%h sof=%b eol=%b",
                           mon_xfers, o_x, o_sof, o_eol, e.x, e.sof, e.eol);
               end
            end
            mon_xfers++;
         end
         prev_stall = o_valid && !i_ready;
         prev_b     = '{x: o_x, sof: o_sof, eol: o_eol};
      end else begin
         prev_stall = 1'b0;
      end
   end

   task automatic push_ramp(input logic [7:0] pix0);
      for (int a = 0; a < NP; a++) begin
         beat_t b;
         b.x   = (a == 0) ? pix0 : 8'(a % 256);
         b.sof = (a == 0);
         b.eol = ((a % W) == W - 1);
         sbq.push_back(b);
      end
   endtask

   task automatic load(input bit all_ff);
      for (int a = 0; a < NP; a++) begin
         @(posedge clk); #1;
         wr_en = 1'b1; wr_addr = 10'(a); wr_data = all_ff ? 8'hFF : 8'(a % 256);
      end
      @(posedge clk); #1;
      wr_addr = 10'd600; wr_data = 8'h55;
      @(posedge clk); #1;
      wr_en = 1'b0;
   endtask

   // Drives one frame and measures it; comparisons are made by the calling test.
   task automatic run_frame(input int rmode, input int poke, input bit w0,
                            output int busy_n, output int stalls, output int first,
                            output int last, output int done_cyc, output int done_n);
      busy_n = 0; stalls = 0; first = -1; last = -1; done_cyc = -1; done_n = 0;
      mon_xfers = 0;
      @(posedge clk); #1;
      start = 1'b1; i_ready = 1'b1;
      if (w0) begin wr_en = 1'b1; wr_addr = '0; wr_data = 8'h77; end
      @(posedge clk); #1;
      start = 1'b0; wr_en = 1'b0;
      for (int c = 1; c <= 3000; c++) begin
         @(negedge clk);
         if (busy) busy_n++;
         if (o_valid) begin
            if (first < 0) first = c;
            last = c;
            if (!i_ready) stalls++;
         end
         if (done) begin
            done_n++;
            if (done_cyc < 0) done_cyc = c;
         end
         if (done_cyc >= 0 && c >= done_cyc + 3) break;
         @(posedge clk); #1;
         start = 1'b0; wr_en = 1'b0;
         i_ready = (rmode == 0) ? 1'b1 : ((c % 4 == 0) || (c % 4 == 3));
         if (c == poke) begin
            start = 1'b1; wr_en = 1'b1; wr_addr = 10'd5; wr_data = 8'hFF;
            coeff_in = ~coeff_in;
         end
      end
      i_ready = 1'b1; start = 1'b0; wr_en = 1'b0;
   endtask

   logic [71:0] coeff_a, coeff_b;

   task automatic test_reset();
      repeat (3) @(posedge clk);
      @(negedge clk);
      n_chk++; if (o_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid: got %b need 0", o_valid); end
      n_chk++; if (busy !== 1'b0)    begin n_fail++; $display("FAIL rst_busy: got %b need 0", busy); end
      n_chk++; if (done !== 1'b0)    begin n_fail++; $display("FAIL rst_done: got %b need 0", done); end
      n_chk++; if (o_x !== 8'h00)    begin n_fail++; $display("FAIL rst_x: got %h need 00", o_x); end
      n_chk++; if (o_f !== 72'h0)    begin n_fail++; $display("FAIL rst_f: got %h need 0", o_f); end
      #2 reset_n = 1'b1;
   endtask

   task automatic test_ramp();
      int bn, st, fi, la, dc, dn;
      coeff_in = coeff_a;
      push_ramp(8'h00);
      mon_en = 1'b1;
      run_frame(0, -1, 1'b0, bn, st, fi, la, dc, dn);
      mon_en = 1'b0;
      n_chk++; if (mon_xfers != NP) begin n_fail++; $display("FAIL ramp_beats: got %0d need %0d", mon_xfers, NP); end
      n_chk++; if (fi != 2)          begin n_fail++; $display("FAIL ramp_first: got cycle %0d need 2", fi); end
      n_chk++; if (la - fi + 1 != NP) begin n_fail++; $display("FAIL ramp_consec: got span %0d need %0d", la - fi + 1, NP); end
      n_chk++; if (dc != la + 1)     begin n_fail++; $display("FAIL ramp_done_cyc: got %0d need %0d", dc, la + 1); end
      n_chk++; if (dn != 1)          begin n_fail++; $display("FAIL ramp_done_cnt: got %0d need 1", dn); end
      n_chk++; if (bn != NP + 2)     begin n_fail++; $display("FAIL ramp_busy: got %0d need %0d", bn, NP + 2); end
      n_chk++; if (o_f !== coeff_a)  begin n_fail++; $display("FAIL ramp_f: got %h need %h", o_f, coeff_a); end
      n_chk++; if (sbq.size() != 0)  begin n_fail++; $display("FAIL ramp_left: got %0d need 0", sbq.size()); end
   endtask

   task automatic test_stall();
      int bn, st, fi, la, dc, dn;
      push_ramp(8'h00);
      mon_en = 1'b1;
      run_frame(1, -1, 1'b0, bn, st, fi, la, dc, dn);
      mon_en = 1'b0;
      n_chk++; if (mon_xfers != NP)  begin n_fail++; $display("FAIL stall_beats: got %0d need %0d", mon_xfers, NP); end
      n_chk++; if (st == 0)          begin n_fail++; $display("FAIL stall_none: got %0d stalls need >0", st); end
      n_chk++; if (bn != NP + 2 + st) begin n_fail++; $display("FAIL stall_busy: got %0d need %0d", bn, NP + 2 + st); end
      n_chk++; if (dc != la + 1)     begin n_fail++; $display("FAIL stall_done_cyc: got %0d need %0d", dc, la + 1); end
      n_chk++; if (sbq.size() != 0)  begin n_fail++; $display("FAIL stall_left: got %0d need 0", sbq.size()); end
   endtask

   task automatic test_ignore();
      int bn, st, fi, la, dc, dn;
      push_ramp(8'h00);
      mon_en = 1'b1;
      run_frame(0, 3, 1'b0, bn, st, fi, la, dc, dn);
      mon_en = 1'b0;
      n_chk++; if (mon_xfers != NP)  begin n_fail++; $display("FAIL ign_beats: got %0d need %0d", mon_xfers, NP); end
      n_chk++; if (bn != NP + 2)     begin n_fail++; $display("FAIL ign_busy: got %0d need %0d", bn, NP + 2); end
      n_chk++; if (dn != 1)          begin n_fail++; $display("FAIL ign_done_cnt: got %0d need 1", dn); end
      n_chk++; if (o_f !== coeff_a)  begin n_fail++; $display("FAIL coeff_hold: got %h need %h", o_f, coeff_a); end
      repeat (3) @(negedge clk);
      n_chk++; if (busy !== 1'b0 || o_valid !== 1'b0) begin
         n_fail++; $display("FAIL ign_restart: got busy=%b valid=%b need 0/0", busy, o_valid);
      end
   endtask

   task automatic test_midreset();
      int bn, st, fi, la, dc, dn, seen;
      push_ramp(8'h00);
      mon_en = 1'b1; mon_xfers = 0;
      @(posedge clk); #1 start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      for (int c = 0; c < 2000 && mon_xfers < 100; c++) @(negedge clk);
      n_chk++; if (mon_xfers < 100) begin n_fail++; $display("FAIL mid_timeout: got %0d beats need 100", mon_xfers); end
      #2 mon_en = 1'b0; reset_n = 1'b0;
      #1;
      n_chk++; if (o_valid !== 1'b0 || busy !== 1'b0 || o_x !== 8'h00) begin
         n_fail++; $display("FAIL mid_rst_out: got v=%b busy=%b x=%h need 0/0/00", o_valid, busy, o_x);
      end
      sbq.delete();
      seen = 0;
      repeat (2) begin @(negedge clk); if (done) seen++; end
      #2 reset_n = 1'b1;
      repeat (4) begin @(negedge clk); if (done || busy) seen++; end
      n_chk++; if (seen != 0) begin n_fail++; $display("FAIL mid_no_done: got %0d done/busy cycles need 0", seen); end
      coeff_in = coeff_b;
      push_ramp(8'h77);
      mon_en = 1'b1;
      run_frame(0, -1, 1'b1, bn, st, fi, la, dc, dn);
      mon_en = 1'b0;
      n_chk++; if (mon_xfers != NP)  begin n_fail++; $display("FAIL mid_beats: got %0d need %0d", mon_xfers, NP); end
      n_chk++; if (o_f !== coeff_b)  begin n_fail++; $display("FAIL mid_f: got %h need %h", o_f, coeff_b); end
      n_chk++; if (sbq.size() != 0)  begin n_fail++; $display("FAIL mid_left: got %0d need 0", sbq.size()); end
   endtask

`ifdef FRAME_STREAMER_CHECKSUM_EN
   task automatic test_checksum();
      int bn, st, fi, la, dc, dn;
      load(1'b1);
      run_frame(0, -1, 1'b0, bn, st, fi, la, dc, dn);
      n_chk++; if (o_checksum !== 16'h3DC0) begin n_fail++; $display("FAIL checksum: got %h need 3dc0", o_checksum); end
      n_chk++; if (dn != 1) begin n_fail++; $display("FAIL cks_done: got %0d need 1", dn); end
   endtask
`endif

   initial begin
      for (int k = 0; k < 9; k++) coeff_a[8*k +: 8] = 8'(k + 1);
      coeff_b = 72'h1122_3344_5566_7788_99;
      test_reset();
      load(1'b0);
      test_ramp();
      test_stall();
      test_ignore();
      test_midreset();
`ifdef FRAME_STREAMER_CHECKSUM_EN
      test_checksum();
`endif
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
